// File: rtl/voice_slot_scheduler_if.sv
// Bus between the frame sequencer and its surroundings: tick source,
// run control, parameter-writer handshake and the per-slot status outputs.
//
// Parameter-writer handshake: param_req is a level the writer holds while it
// wants a window. param_gnt is the ready side: a patch/matrix write may land
// only in a cycle where param_gnt=1. The writer closes the window by pulsing
// param_done during a granted cycle or by dropping param_req; the sequencer
// may also close it on its own after the maximum grant length.
interface voice_slot_scheduler_if #(
    parameter int IDX_W = 9
);
    logic             sample_tick;
    logic             run_en;
    logic             param_req;
    logic             param_done;
    logic [IDX_W-1:0] xxxx;
    logic             xxxx_zero;
    logic             frame_busy;
    logic             frame_done;
    logic             param_gnt;
    logic [7:0]       overrun_cnt;
    logic [1:0]       state_dbg;

    // Environment side: tick source, run control and parameter writer.
    modport master (
        output sample_tick, run_en, param_req, param_done,
        input  xxxx, xxxx_zero, frame_busy, frame_done, param_gnt,
               overrun_cnt, state_dbg
    );

    // Sequencer side.
    modport slave (
        input  sample_tick, run_en, param_req, param_done,
        output xxxx, xxxx_zero, frame_busy, frame_done, param_gnt,
               overrun_cnt, state_dbg
    );
endinterface

// File: rtl/voice_slot_scheduler.sv
// Frame sequencer for the voice/oscillator/envelope mixer. Each accepted
// sample tick sweeps the slot index over every {voice, osc, env} slot, waits
// for the mixer pipeline to drain, then reports the frame as done. Between
// frames the parameter writer can be granted a window so updates never land
// mid-frame. Ticks arriving while busy are remembered once; further ones are
// dropped and counted.
module voice_slot_scheduler #(
    parameter int VOICES    = 32,
    parameter int V_OSC     = 8,
    parameter int O_ENVS    = 2,
    parameter int V_ENVS    = V_OSC * O_ENVS,
    parameter int V_WIDTH   = $clog2(VOICES),
    parameter int E_WIDTH   = $clog2(V_ENVS),
    parameter int SLOTS     = VOICES * V_ENVS,
    parameter int DRAIN_CYC = 8,
    parameter int GNT_MAX   = 64
) (
    input logic                   sCLK_XVXENVS,
    input logic                   reset,
    voice_slot_scheduler_if.slave bus
);

    localparam int IDX_W   = V_WIDTH + E_WIDTH;
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
    localparam int GNT_W   = $clog2(GNT_MAX + 1);

    localparam logic [IDX_W-1:0]   LAST_SLOT  = IDX_W'(SLOTS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [GNT_W-1:0]   LAST_GNT   = GNT_W'(GNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GRANT = 2'd3
    } state_e;

    state_e             state_q,       state_d;
    logic [IDX_W-1:0]   xxxx_q,        xxxx_d;
    logic               xxxx_zero_q,   xxxx_zero_d;
    logic               frame_busy_q,  frame_busy_d;
    logic               frame_done_q,  frame_done_d;
    logic               param_gnt_q,   param_gnt_d;
    logic [7:0]         overrun_cnt_q, overrun_cnt_d;
    logic               pending_q,     pending_d;
    logic [DRAIN_W-1:0] drain_cnt_q,   drain_cnt_d;
    logic [GNT_W-1:0]   gnt_cnt_q,     gnt_cnt_d;

    logic tick_ok;

    // A tick only matters while frames are enabled.
    assign tick_ok = bus.sample_tick & bus.run_en;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        xxxx_d        = xxxx_q;
        xxxx_zero_d   = 1'b0;
        frame_busy_d  = 1'b0;
        frame_done_d  = 1'b0;
        param_gnt_d   = 1'b0;
        overrun_cnt_d = overrun_cnt_q;
        pending_d     = pending_q;
        drain_cnt_d   = drain_cnt_q;
        gnt_cnt_d     = gnt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Frame start beats a parameter request; a fresh tick in the
                // same cycle a pending one is consumed becomes the new pending.
                if ((bus.sample_tick | pending_q) & bus.run_en) begin
                    state_d      = ST_SCAN;
                    xxxx_d       = '0;
                    xxxx_zero_d  = 1'b1;
                    frame_busy_d = 1'b1;
                    pending_d    = pending_q & tick_ok;
                end else if (bus.param_req) begin
                    state_d     = ST_GRANT;
                    param_gnt_d = 1'b1;
                    gnt_cnt_d   = '0;
                end
            end

            ST_SCAN: begin
                frame_busy_d = 1'b1;
                if (xxxx_q == LAST_SLOT) begin
                    state_d     = ST_DRAIN;
                    xxxx_d      = '0;
                    drain_cnt_d = '0;
                end else begin
                    xxxx_d = xxxx_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    frame_busy_d = 1'b1;
                    drain_cnt_d  = drain_cnt_q + 1'b1;
                end
            end

            ST_GRANT: begin
                if (bus.param_done | ~bus.param_req | (gnt_cnt_q == LAST_GNT)) begin
                    state_d = ST_IDLE;
                end else begin
                    param_gnt_d = 1'b1;
                    gnt_cnt_d   = gnt_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ticks while busy or granting: remember one, count the rest.
        if ((state_q != ST_IDLE) && tick_ok) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (overrun_cnt_q != 8'hFF) begin
                overrun_cnt_d = overrun_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset aborts any frame or grant at once.
    always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            xxxx_q        <= '0;
            xxxx_zero_q   <= 1'b0;
            frame_busy_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            param_gnt_q   <= 1'b0;
            overrun_cnt_q <= '0;
            pending_q     <= 1'b0;
            drain_cnt_q   <= '0;
            gnt_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            xxxx_q        <= xxxx_d;
            xxxx_zero_q   <= xxxx_zero_d;
            frame_busy_q  <= frame_busy_d;
            frame_done_q  <= frame_done_d;
            param_gnt_q   <= param_gnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            pending_q     <= pending_d;
            drain_cnt_q   <= drain_cnt_d;
            gnt_cnt_q     <= gnt_cnt_d;
        end
    end

    assign bus.xxxx        = xxxx_q;
    assign bus.xxxx_zero   = xxxx_zero_q;
    assign bus.frame_busy  = frame_busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.param_gnt   = param_gnt_q;
    assign bus.overrun_cnt = overrun_cnt_q;
    assign bus.state_dbg   = state_q;

    // The writer window must never overlap a frame.
    a_no_gnt_in_frame: assert property (
        @(posedge sCLK_XVXENVS) disable iff (reset) !(param_gnt_q & frame_busy_q)
    );

endmodule
